mux_pipe_sel: RTL

- Parametrised N-way, W-bit select stage with registered output and valid/ready handshake on both sides.
- Successor to the plain 2:1 32-bit operand mux used in the datapath.
- Sits between pipeline stages wherever a selected operand must be registered and stalled independently, for example a forwarding-source select in front of the ALU/MDU.
- A two-entry skid buffer sustains one transfer per cycle under downstream backpressure.

---
 rtl/mux_pkg.sv | 20 ++
 rtl/mux_nsel.sv | 28 ++
 rtl/mux_pipe_sel.sv | 105 ++++++++++
 3 files changed

// File: rtl/mux_pkg.sv
// rtl/mux_pkg.sv - shared constants, entry type and lane helper for the select stage
package mux_pkg;

    localparam int DEFAULT_WIDTH = 32;
    localparam int MAX_IN        = 16;

    typedef struct packed {
        logic                     valid;
        logic                     err;
        logic [DEFAULT_WIDTH-1:0] data;
    } mux_entry_t;

    function automatic logic [DEFAULT_WIDTH-1:0] lane_sel(
        input logic [MAX_IN*DEFAULT_WIDTH-1:0] packed_lanes,
        input logic [3:0]                      idx
    );
        return packed_lanes[idx*DEFAULT_WIDTH +: DEFAULT_WIDTH];
    endfunction

endpackage

// File: rtl/mux_nsel.sv
// rtl/mux_nsel.sv - combinational N-way lane selector with out-of-range detect
// An out-of-range index yields lane 0 and raises o_oor.
module mux_nsel
    import mux_pkg::*;
#(
    parameter int WIDTH  = DEFAULT_WIDTH,
    parameter int NUM_IN = 4
) (
    input  logic [NUM_IN*WIDTH-1:0]   i_data,
    input  logic [$clog2(NUM_IN)-1:0] i_sel,
    output logic [WIDTH-1:0]          o_data,
    output logic                      o_oor
);
    localparam int SEL_W = $clog2(NUM_IN);

    // NUM_IN <= 2**SEL_W, so one extra bit holds the bound without truncation
    assign o_oor = ({1'b0, i_sel} >= (SEL_W+1)'(NUM_IN));

    always_comb begin
        o_data = i_data[0 +: WIDTH];
        for (int i = 1; i < NUM_IN; i++) begin
            if (i_sel == SEL_W'(i)) begin
                o_data = i_data[i*WIDTH +: WIDTH];
            end
        end
    end

endmodule

// File: rtl/mux_pipe_sel.sv
// rtl/mux_pipe_sel.sv - registered N-way select stage with two-entry skid buffer
// Out-of-range select flagging on out_err is built only when MUX_SEL_CHECK_EN is defined.
module mux_pipe_sel
    import mux_pkg::*;
#(
    parameter int WIDTH  = DEFAULT_WIDTH,
    parameter int NUM_IN = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      flush,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [$clog2(NUM_IN)-1:0] in_sel,
    input  logic [NUM_IN*WIDTH-1:0]   in_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [WIDTH-1:0]          out_data,
    output logic                      out_err
);
    logic             r_mv;
    logic             r_sv;
    logic [WIDTH-1:0] r_m_data;
    logic [WIDTH-1:0] r_s_data;
    logic [WIDTH-1:0] w_sel_data;
    logic [WIDTH-1:0] w_cap_data;
    logic             w_oor;
    logic             w_accept;
    logic             w_pop;
    logic             w_load_m;
    logic             w_skid_to_m;

    mux_nsel #(
        .WIDTH  (WIDTH),
        .NUM_IN (NUM_IN)
    ) u_nsel (
        .i_data (in_data),
        .i_sel  (in_sel),
        .o_data (w_sel_data),
        .o_oor  (w_oor)
    );

    assign in_ready    = !r_sv;
    assign w_accept    = in_valid && !r_sv;
    assign w_pop       = r_mv && out_ready;
    // M takes the incoming beat when it is empty or draining with no skid entry behind it
    assign w_load_m    = !r_mv || (w_pop && !r_sv);
    assign w_skid_to_m = w_pop && r_sv;

    assign out_valid = r_mv;
    assign out_data  = r_m_data;

`ifdef MUX_SEL_CHECK_EN
    logic r_m_err;
    logic r_s_err;

    assign w_cap_data = w_oor ? '0 : w_sel_data;
    assign out_err    = r_m_err;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_m_err <= 1'b0;
            r_s_err <= 1'b0;
        end else if (!flush) begin
            if (w_load_m && w_accept) begin
                r_m_err <= w_oor;
            end else if (w_skid_to_m) begin
                r_m_err <= r_s_err;
            end else if (!w_load_m && w_accept) begin
                r_s_err <= w_oor;
            end
        end
    end
`else
    logic w_unused_oor;

    assign w_unused_oor = w_oor;
    assign w_cap_data   = w_sel_data;
    assign out_err      = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_mv     <= 1'b0;
            r_sv     <= 1'b0;
            r_m_data <= '0;
            r_s_data <= '0;
        end else if (flush) begin
            r_mv <= 1'b0;
            r_sv <= 1'b0;
        end else if (w_load_m) begin
            r_mv <= w_accept;
            if (w_accept) begin
                r_m_data <= w_cap_data;
            end
        end else if (w_skid_to_m) begin
            r_m_data <= r_s_data;
            r_sv     <= 1'b0;
        end else if (w_accept) begin
            r_s_data <= w_cap_data;
            r_sv     <= 1'b1;
        end
    end

endmodule
